// File: rtl/wb_mem_pkg.sv
// Shared definitions for the wb_mem_resp responder: FSM state encoding,
// access-kind classification, default geometry and the byte sign-extend helper.
package wb_mem_pkg;

  // Default RAM geometry: 2^13 words of 16 bits.
  localparam int unsigned DEFAULT_AW      = 13;
  // First byte address of the optional read-only window.
  localparam logic [19:0] DEFAULT_RO_BASE = 20'hc0000;

  // FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD_LO = 3'd1;
  localparam state_t ST_RD_HI = 3'd2;
  localparam state_t ST_WR_HI = 3'd3;
  localparam state_t ST_ACK   = 3'd4;

  // How a request maps onto RAM words.
  typedef enum logic [1:0] {
    ACC_BYTE      = 2'd0,
    ACC_WORD_EVEN = 2'd1,
    ACC_WORD_ODD  = 2'd2
  } acc_kind_e;

  // Classify a request from its byte flag and address bit 0.
  function automatic acc_kind_e acc_kind(input logic is_byte, input logic odd);
    if (is_byte)  return ACC_BYTE;
    else if (odd) return ACC_WORD_ODD;
    else          return ACC_WORD_EVEN;
  endfunction

  // Sign-extend a byte to a 16-bit word.
  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/wb_mem_resp_ram.sv
// Single-port synchronous RAM, 2^AW x 16, with two byte-lane write enables
// and a one-cycle registered read. Contents are never reset.
module wb_mem_resp_ram #(
  parameter int unsigned AW = 13
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  input  logic [1:0]    be_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [0:(1<<AW)-1];
  logic [15:0] rdata_q;

  // Lane writes and the read of the addressed word (old data on a same-cycle write).
  always_ff @(posedge clk_i) begin
    if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_resp.sv
// Wishbone-style memory responder on a 20-bit byte-addressed, 16-bit bus.
// Serves aligned words, odd-address words (split into two RAM cycles) and
// sign-extended byte reads / single-lane byte writes.
//
// Handshake: a request is taken when stb_i is high while the FSM is idle
// (IDLE, or ACK, which is the idle cycle carrying the ack pulse). Address,
// data, we_i and byte_i are latched at that edge; ack_o is high for exactly
// one cycle per accepted request, and the initiator must present the next
// request (or drop stb_i) within the ack cycle, which allows back-to-back
// transfers with stb_i held high.
//
// Optional build macro WB_MEM_RO_WINDOW_EN: when defined, byte addresses at
// or above RO_BASE are read-only (writes are dropped but still acked). Each
// half of an odd word write is checked on its own byte address.
module wb_mem_resp
  import wb_mem_pkg::*;
#(
  parameter int unsigned AW      = DEFAULT_AW,
  parameter logic [19:0] RO_BASE = DEFAULT_RO_BASE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [19:0] adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        byte_i,
  output logic        ack_o
);

`ifdef WB_MEM_RO_WINDOW_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  // FSM and output registers.
  state_t      state_q, state_d;
  logic [15:0] dat_o_q, dat_o_d;

  // Request captured at the accept edge.
  logic [19:0] adr_q;
  acc_kind_e   kind_q;
  logic [7:0]  dat_hi_q;

  // Low byte of an odd word read, held while the second word is fetched.
  logic [7:0]  lo_byte_q, lo_byte_d;

  // RAM port.
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [1:0]    ram_be;
  logic [1:0]    ram_be_gated;
  logic [15:0]   ram_rdata;

  // Address math.
  logic          idle_like;
  logic          accept;
  acc_kind_e     kind_in;
  logic [AW-1:0] widx_in;
  logic [AW-1:0] widx_nx;
  logic [19:0]   adr_nx;
  logic          ro_lo;
  logic          ro_hi;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_ACK);
  assign accept    = idle_like && stb_i && !rst_i;
  assign kind_in   = acc_kind(byte_i, adr_i[0]);
  assign widx_in   = adr_i[AW:1];
  // Second word of an odd access; wraps from the top word to word 0.
  assign widx_nx   = adr_q[AW:1] + AW'(1);
  assign adr_nx    = adr_q + 20'd1;
  assign ro_lo     = RO_EN && (adr_i  >= RO_BASE);
  assign ro_hi     = RO_EN && (adr_nx >= RO_BASE);

  // Next-state, RAM steering and read-data assembly.
  always_comb begin
    state_d   = state_q;
    dat_o_d   = dat_o_q;
    lo_byte_d = lo_byte_q;
    ram_addr  = widx_in;
    ram_wdata = {dat_i[7:0], dat_i[7:0]};
    ram_be    = 2'b00;

    case (state_q)
      ST_IDLE, ST_ACK: begin
        if (stb_i) begin
          if (we_i) begin
            unique case (kind_in)
              ACC_WORD_EVEN: begin
                ram_wdata = dat_i;
                ram_be    = ro_lo ? 2'b00 : 2'b11;
                state_d   = ST_ACK;
              end
              ACC_BYTE: begin
                ram_be    = ro_lo ? 2'b00 : (adr_i[0] ? 2'b10 : 2'b01);
                state_d   = ST_ACK;
              end
              ACC_WORD_ODD: begin
                // Low data byte goes to the high lane of the first word.
                ram_be    = ro_lo ? 2'b00 : 2'b10;
                state_d   = ST_WR_HI;
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_RD_LO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_LO: begin
        ram_addr = widx_nx;
        if (kind_q == ACC_WORD_ODD) begin
          lo_byte_d = ram_rdata[15:8];
          state_d   = ST_RD_HI;
        end else if (kind_q == ACC_BYTE) begin
          dat_o_d   = sext8(adr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0]);
          state_d   = ST_ACK;
        end else begin
          dat_o_d   = ram_rdata;
          state_d   = ST_ACK;
        end
      end

      ST_RD_HI: begin
        dat_o_d = {ram_rdata[7:0], lo_byte_q};
        state_d = ST_ACK;
      end

      ST_WR_HI: begin
        // High data byte goes to the low lane of the following word.
        ram_addr  = widx_nx;
        ram_wdata = {dat_hi_q, dat_hi_q};
        ram_be    = ro_hi ? 2'b00 : 2'b01;
        state_d   = ST_ACK;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Reset wins over any pending lane write, so an interrupted odd write
  // keeps its first half and never writes the second.
  assign ram_be_gated = rst_i ? 2'b00 : ram_be;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      dat_o_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      dat_o_q <= dat_o_d;
    end
  end

  // Request capture and read-assembly scratch; no reset needed.
  always_ff @(posedge clk_i) begin
    lo_byte_q <= lo_byte_d;
    if (accept) begin
      adr_q    <= adr_i;
      kind_q   <= kind_in;
      dat_hi_q <= dat_i[15:8];
    end
  end

  wb_mem_resp_ram #(.AW(AW)) u_ram (
    .clk_i   (clk_i),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .be_i    (ram_be_gated),
    .rdata_o (ram_rdata)
  );

  assign ack_o = (state_q == ST_ACK);
  assign dat_o = dat_o_q;

endmodule

// File: tb/tb_wb_mem_resp.sv
// Bench for wb_mem_resp: table of directed vectors, a hand-written reset
// sequence, then a randomized back-to-back burst scored against a byte-level
// memory model.
module tb_wb_mem_resp;

  localparam int          AW      = 4;
  localparam int          NB      = 2 ** (AW + 1);
  localparam logic [19:0] RO_BASE = 20'hc0000;
  localparam int          N_RAND  = 200;

  // Clock / reset.
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [19:0] adr_i = '0;
  logic [15:0] dat_i = '0;
  logic [15:0] dat_o;
  logic        we_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        byte_i = 1'b0;
  logic        ack_o;

  always #5 clk_i = ~clk_i;

  wb_mem_resp #(.AW(AW), .RO_BASE(RO_BASE)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .we_i   (we_i),
    .stb_i  (stb_i),
    .byte_i (byte_i),
    .ack_o  (ack_o)
  );

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;

  // Reference model: the RAM as a flat array of bytes, aliased modulo its size.
  logic [7:0]  mb [NB];
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] exp_q [$];

  typedef struct {
    logic        we;
    logic        byt;
    logic [19:0] adr;
    logic [15:0] dat;
    logic [15:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs [$];

  always @(negedge clk_i) if (ack_o) ack_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_ro(input logic [19:0] a);
`ifdef WB_MEM_RO_WINDOW_EN
    return a >= RO_BASE;
`else
    return (a != a);
`endif
  endfunction

  // A word access covers byte a and byte a+1; a byte access only byte a.
  task automatic model_write(input logic byt, input logic [19:0] a, input logic [15:0] d,
                             input bit first_only);
    logic [19:0] a1;
    a1 = a + 20'd1;
    if (!in_ro(a)) mb[a[AW:0]] = d[7:0];
    if (!byt && !first_only && !in_ro(a1)) mb[a1[AW:0]] = d[15:8];
  endtask

  function automatic logic [15:0] model_read(input logic byt, input logic [19:0] a);
    logic [19:0] a1;
    logic [7:0]  b;
    a1 = a + 20'd1;
    b  = mb[a[AW:0]];
    if (byt) return {{8{b[7]}}, b};
    return {mb[a1[AW:0]], b};
  endfunction

  // Latency: one cycle per RAM touch for writes, plus one for reads.
  function automatic int model_lat(input logic we, input logic byt, input logic [19:0] a);
    int touches;
    touches = (!byt && a[0]) ? 2 : 1;
    return we ? touches : touches + 1;
  endfunction

  // Driver: present a request at a negedge and wait (bounded) for its ack.
  task automatic req(input logic we, input logic byt, input logic [19:0] a,
                     input logic [15:0] d, output int lat);
    we_i = we; byte_i = byt; adr_i = a; dat_i = d; stb_i = 1'b1;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (ack_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    req(v.we, v.byt, v.adr, v.dat, lat);
    check($sformatf("vec%0d latency", idx), lat, v.lat);
    if (v.we) begin
      check($sformatf("vec%0d dat_hold", idx), dat_o, last_rd);
      model_write(v.byt, v.adr, v.dat, 1'b0);
    end else begin
      check($sformatf("vec%0d rdata", idx), dat_o, v.exp);
      last_rd = v.exp;
    end
    stb_i = 1'b0;
    @(negedge clk_i);
    check($sformatf("vec%0d ack_pulse", idx), ack_o, 1'b0);
  endtask

  function automatic vec_t mkv(input logic we, input logic byt, input logic [19:0] a,
                               input logic [15:0] d, input logic [15:0] e, input int l);
    vec_t v;
    v.we = we; v.byt = byt; v.adr = a; v.dat = d; v.exp = e; v.lat = l;
    return v;
  endfunction

  initial begin
    int lat;
    int snap;
    logic [15:0] e;
    logic w, b;
    logic [19:0] a;
    logic [15:0] d;

    // Reset.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset ack", ack_o, 1'b0);
    check("reset dat_o", dat_o, 16'h0000);
    rst_i = 1'b0;

    // Give every RAM word known contents, back to back.
    for (int wi = 0; wi < NB / 2; wi++) begin
      d = 16'($urandom);
      req(1'b1, 1'b0, 20'(2 * wi), d, lat);
      check("fill latency", lat, 1);
      model_write(1'b0, 20'(2 * wi), d, 1'b0);
    end
    stb_i = 1'b0;
    @(negedge clk_i);

    // Directed vectors: we, byte, adr, dat, expected read, latency.
    vecs.push_back(mkv(1, 0, 20'h00004, 16'h0a0b, 16'h0000, 1));
    vecs.push_back(mkv(0, 0, 20'h00004, 16'h0000, 16'h0a0b, 2));
    vecs.push_back(mkv(1, 0, 20'h00010, 16'h1234, 16'h0000, 1));
    vecs.push_back(mkv(1, 1, 20'h00011, 16'h008c, 16'h0000, 1));
    vecs.push_back(mkv(0, 0, 20'h00010, 16'h0000, 16'h8c34, 2));
    vecs.push_back(mkv(0, 1, 20'h00011, 16'h0000, 16'hff8c, 2));
    vecs.push_back(mkv(0, 1, 20'h00010, 16'h0000, 16'h0034, 2));
    vecs.push_back(mkv(1, 0, 20'h00002, 16'h1234, 16'h0000, 1));
    vecs.push_back(mkv(1, 0, 20'h00004, 16'h5678, 16'h0000, 1));
    vecs.push_back(mkv(0, 0, 20'h00003, 16'h0000, 16'h7812, 3));
    vecs.push_back(mkv(1, 0, 20'h00003, 16'habcd, 16'h0000, 2));
    vecs.push_back(mkv(0, 0, 20'h00002, 16'h0000, 16'hcd34, 2));
    vecs.push_back(mkv(0, 0, 20'h00004, 16'h0000, 16'h56ab, 2));
    vecs.push_back(mkv(1, 1, 20'h00005, 16'h007f, 16'h0000, 1));
    vecs.push_back(mkv(0, 1, 20'h00005, 16'h0000, 16'h007f, 2));
    vecs.push_back(mkv(0, 0, 20'h00004, 16'h0000, 16'h7fab, 2));
    vecs.push_back(mkv(1, 0, 20'h0001e, 16'h0000, 16'h0000, 1));
    vecs.push_back(mkv(1, 0, 20'h00000, 16'h0000, 16'h0000, 1));
    vecs.push_back(mkv(1, 0, 20'h0001f, 16'hbeef, 16'h0000, 2));
    vecs.push_back(mkv(0, 0, 20'h0001e, 16'h0000, 16'hef00, 2));
    vecs.push_back(mkv(0, 0, 20'h00000, 16'h0000, 16'h00be, 2));
    vecs.push_back(mkv(0, 0, 20'h0001f, 16'h0000, 16'hbeef, 3));
    vecs.push_back(mkv(1, 0, 20'hc0002, 16'h1111, 16'h0000, 1));
`ifdef WB_MEM_RO_WINDOW_EN
    vecs.push_back(mkv(0, 0, 20'h00002, 16'h0000, 16'hcd34, 2));
    vecs.push_back(mkv(0, 0, 20'hc0003, 16'h0000, 16'habcd, 3));
`else
    vecs.push_back(mkv(0, 0, 20'h00002, 16'h0000, 16'h1111, 2));
    vecs.push_back(mkv(0, 0, 20'hc0003, 16'h0000, 16'hab11, 3));
`endif
    vecs.push_back(mkv(1, 1, 20'h00000, 16'h0083, 16'h0000, 1));
    vecs.push_back(mkv(0, 1, 20'h00000, 16'h0000, 16'hff83, 2));
    vecs.push_back(mkv(0, 0, 20'h00000, 16'h0000, 16'h0083, 2));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset in the second half of an odd write at the top word.
    we_i = 1'b1; byte_i = 1'b0; adr_i = 20'h0001f; dat_i = 16'h1357; stb_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    stb_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst ack", ack_o, 1'b0);
    check("midrst dat_o", dat_o, 16'h0000);
    rst_i = 1'b0;
    model_write(1'b0, 20'h0001f, 16'h1357, 1'b1);
    last_rd = 16'h0000;
    repeat (2) begin
      @(negedge clk_i);
      check("midrst no_ack", ack_o, 1'b0);
    end
    run_vec(mkv(0, 0, 20'h0001e, 16'h0000, 16'h5700, 2), 100);
    run_vec(mkv(0, 0, 20'h00000, 16'h0000, 16'h0083, 2), 101);

    // Randomized back-to-back burst with stb_i held high throughout.
    snap = ack_cnt;
    for (int i = 0; i < N_RAND; i++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = 20'($urandom_range(0, 20'hfffff));
      if ($urandom_range(0, 3) == 0) a = 20'($urandom_range(0, NB - 1));
      d = 16'($urandom);
      if (w) model_write(b, a, d, 1'b0);
      else   exp_q.push_back(model_read(b, a));
      req(w, b, a, d, lat);
      check($sformatf("rand%0d latency", i), lat, model_lat(w, b, a));
      if (w) begin
        check($sformatf("rand%0d dat_hold", i), dat_o, last_rd);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rand%0d rdata", i), dat_o, e);
        last_rd = e;
      end
    end
    stb_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("burst ack_count", ack_cnt - snap, N_RAND);
    check("burst idle_ack", ack_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
